// File: rtl/deser8_if.sv
// deser8_if: serial input, control and held-word handshake bundle for deser8
//   clr            synchronous clear of partial and held word
//   s_valid, s_in  one serial bit per qualified clock
//   d_out, d_valid held word and its full flag
//   d_ready        consumer accepts d_out when d_valid & d_ready
//   busy, bit_cnt  partial-word status
//   overrun        sticky dropped-word flag
interface deser8_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
);
   logic             clr;
   logic             s_valid;
   logic             s_in;
   logic             d_ready;
   logic [WIDTH-1:0] d_out;
   logic             d_valid;
   logic             busy;
   logic [CNT_W-1:0] bit_cnt;
   logic             overrun;
   modport master (
      output clr, s_valid, s_in, d_ready,
      input  d_out, d_valid, busy, bit_cnt, overrun
   );
   modport slave (
      input  clr, s_valid, s_in, d_ready,
      output d_out, d_valid, busy, bit_cnt, overrun
   );
endinterface

// File: rtl/deser8.sv
// deser8: serial-to-parallel receiver with a one-entry valid/ready holding register
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    deser8_if.slave: serial bits in, held word out, status flags
module deser8 #(
   parameter int WIDTH     = 8,
   parameter int CNT_W     = 3,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic     clk,
   input logic     reset,
   deser8_if.slave bus
);
   typedef enum logic {IDLE, RECV} state_t;
   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_shreg, w_shreg_nxt, w_word, r_dout;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_dvalid, r_busy, r_overrun;
   logic             w_last, w_load, w_drop, w_accept;
   // assembled word including the bit sampled this cycle
   assign w_word   = MSB_FIRST ? {r_shreg[WIDTH-2:0], bus.s_in} : {bus.s_in, r_shreg[WIDTH-1:1]};
   assign w_last   = bus.s_valid && r_cnt == CNT_W'(WIDTH-1);
   assign w_accept = r_dvalid & bus.d_ready;
   // a completing word lands if the holding register is empty or emptied this edge
   assign w_load   = !bus.clr && w_last && (!r_dvalid || bus.d_ready);
   assign w_drop   = !bus.clr && w_last && r_dvalid && !bus.d_ready;
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shreg_nxt = r_shreg;
      if (bus.clr) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
         w_shreg_nxt = '0;
      end else if (bus.s_valid) begin
         w_shreg_nxt = w_word;
         w_cnt_nxt   = w_last ? '0 : r_cnt + CNT_W'(1);
         w_state_nxt = w_last ? IDLE : RECV;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_shreg   <= '0;
         r_dout    <= '0;
         r_dvalid  <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_shreg   <= w_shreg_nxt;
         r_busy    <= w_cnt_nxt != '0;
         if (w_load) r_dout <= w_word;
         r_dvalid  <= bus.clr ? 1'b0 : w_load ? 1'b1 : w_accept ? 1'b0 : r_dvalid;
         r_overrun <= bus.clr ? 1'b0 : (r_overrun | w_drop);
      end
   end
   assign bus.d_out   = r_dout;
   assign bus.d_valid = r_dvalid;
   assign bus.busy    = r_busy;
   assign bus.bit_cnt = r_cnt;
   assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_deser8.sv
// tb_deser8: directed checks of MSB-first and LSB-first deser8 instances
module tb_deser8;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clr = 1'b0, s_valid = 1'b0, s_in = 1'b0, d_ready = 1'b0;
   int total = 0, bad = 0;
   deser8_if #(.WIDTH(8), .CNT_W(3)) ifm ();
   deser8_if #(.WIDTH(8), .CNT_W(3)) ifl ();
   assign ifm.clr = clr;
   assign ifm.s_valid = s_valid;
   assign ifm.s_in = s_in;
   assign ifm.d_ready = d_ready;
   assign ifl.clr = clr;
   assign ifl.s_valid = s_valid;
   assign ifl.s_in = s_in;
   assign ifl.d_ready = d_ready;
   deser8 #(.WIDTH(8), .CNT_W(3), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .bus(ifm.slave));
   deser8 #(.WIDTH(8), .CNT_W(3), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .bus(ifl.slave));
   always #5 clk = ~clk;
   task automatic send_bit(input logic b, input logic rdy);
      s_valid = 1'b1;
      s_in = b;
      d_ready = rdy;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      d_ready = 1'b0;
   endtask
   task automatic send_word(input logic [7:0] w, input logic rdy_last);
      for (int i = 7; i >= 0; i--) send_bit(w[i], i == 0 ? rdy_last : 1'b0);
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic pulse_clr();
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask
   task automatic test_reset();
      #3;
      total++;
      if ({ifm.d_out, ifm.d_valid, ifm.busy, ifm.bit_cnt, ifm.overrun} !== 14'h0) begin
         bad++;
         $display("FAIL reset_msb got=%h want=0", {ifm.d_out, ifm.d_valid, ifm.busy, ifm.bit_cnt, ifm.overrun});
      end
      total++;
      if ({ifl.d_out, ifl.d_valid, ifl.busy, ifl.bit_cnt, ifl.overrun} !== 14'h0) begin
         bad++;
         $display("FAIL reset_lsb got=%h want=0", {ifl.d_out, ifl.d_valid, ifl.busy, ifl.bit_cnt, ifl.overrun});
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask
   task automatic test_order();
      logic [7:0] bits;
      bits = 8'h77;
      for (int i = 7; i >= 0; i--) begin
         send_bit(bits[i], 1'b0);
         if (i > 0) begin
            total++;
            if (ifm.busy !== 1'b1 || ifm.bit_cnt !== 3'(8 - i)) begin
               bad++;
               $display("FAIL busy_cnt bit%0d got busy=%b cnt=%0d want busy=1 cnt=%0d", 8 - i, ifm.busy, ifm.bit_cnt, 8 - i);
            end
         end
      end
      total++;
      if (ifm.d_out !== 8'h77 || ifm.d_valid !== 1'b1 || ifm.busy !== 1'b0) begin
         bad++;
         $display("FAIL msb_word got=%h v=%b busy=%b want=77 v=1 busy=0", ifm.d_out, ifm.d_valid, ifm.busy);
      end
      total++;
      if (ifl.d_out !== 8'hEE || ifl.d_valid !== 1'b1) begin
         bad++;
         $display("FAIL lsb_word got=%h v=%b want=ee v=1", ifl.d_out, ifl.d_valid);
      end
   endtask
   task automatic test_overrun();
      pulse_clr();
      send_word(8'h3C, 1'b0);
      total++;
      if (ifm.d_out !== 8'h3C || ifm.d_valid !== 1'b1 || ifm.overrun !== 1'b0) begin
         bad++;
         $display("FAIL first_word got=%h v=%b ov=%b want=3c v=1 ov=0", ifm.d_out, ifm.d_valid, ifm.overrun);
      end
      send_word(8'h5A, 1'b0);
      total++;
      if (ifm.d_out !== 8'h3C || ifm.d_valid !== 1'b1 || ifm.overrun !== 1'b1) begin
         bad++;
         $display("FAIL drop got=%h v=%b ov=%b want=3c v=1 ov=1", ifm.d_out, ifm.d_valid, ifm.overrun);
      end
      total++;
      if (ifl.d_out !== 8'h3C || ifl.overrun !== 1'b1) begin
         bad++;
         $display("FAIL drop_lsb got=%h ov=%b want=3c ov=1", ifl.d_out, ifl.overrun);
      end
      idle(2);
      total++;
      if (ifm.overrun !== 1'b1) begin
         bad++;
         $display("FAIL sticky got=%b want=1", ifm.overrun);
      end
      pulse_clr();
      total++;
      if (ifm.d_valid !== 1'b0 || ifm.overrun !== 1'b0 || ifm.d_out !== 8'h3C || ifm.bit_cnt !== 3'd0) begin
         bad++;
         $display("FAIL clr got v=%b ov=%b d=%h cnt=%0d want v=0 ov=0 d=3c cnt=0", ifm.d_valid, ifm.overrun, ifm.d_out, ifm.bit_cnt);
      end
   endtask
   task automatic test_back_to_back();
      send_word(8'h77, 1'b0);
      send_word(8'h87, 1'b1);
      total++;
      if (ifm.d_out !== 8'h87 || ifm.d_valid !== 1'b1 || ifm.overrun !== 1'b0) begin
         bad++;
         $display("FAIL replace got=%h v=%b ov=%b want=87 v=1 ov=0", ifm.d_out, ifm.d_valid, ifm.overrun);
      end
      d_ready = 1'b1;
      idle(1);
      total++;
      if (ifm.d_valid !== 1'b0 || ifm.d_out !== 8'h87) begin
         bad++;
         $display("FAIL accept got v=%b d=%h want v=0 d=87", ifm.d_valid, ifm.d_out);
      end
      idle(1);
      d_ready = 1'b0;
      total++;
      if (ifm.d_valid !== 1'b0 || ifm.d_out !== 8'h87 || ifm.overrun !== 1'b0) begin
         bad++;
         $display("FAIL idle_ready got v=%b d=%h ov=%b want v=0 d=87 ov=0", ifm.d_valid, ifm.d_out, ifm.overrun);
      end
   endtask
   task automatic test_gap();
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         total++;
         if (ifm.bit_cnt !== 3'd4 || ifm.busy !== 1'b1) begin
            bad++;
            $display("FAIL gap%0d got cnt=%0d busy=%b want cnt=4 busy=1", i, ifm.bit_cnt, ifm.busy);
         end
      end
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      total++;
      if (ifm.d_out !== 8'hC3 || ifm.d_valid !== 1'b1 || ifm.bit_cnt !== 3'd0) begin
         bad++;
         $display("FAIL gap_word got=%h v=%b cnt=%0d want=c3 v=1 cnt=0", ifm.d_out, ifm.d_valid, ifm.bit_cnt);
      end
   endtask
   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
      total++;
      if (ifm.bit_cnt !== 3'd5) begin
         bad++;
         $display("FAIL pre_reset got cnt=%0d want 5", ifm.bit_cnt);
      end
      #2;
      reset = 1'b1;
      #1;
      total++;
      if ({ifm.d_out, ifm.d_valid, ifm.busy, ifm.bit_cnt, ifm.overrun} !== 14'h0) begin
         bad++;
         $display("FAIL async_reset got=%h want=0", {ifm.d_out, ifm.d_valid, ifm.busy, ifm.bit_cnt, ifm.overrun});
      end
      @(negedge clk);
      reset = 1'b0;
      send_word(8'hA5, 1'b0);
      total++;
      if (ifm.d_out !== 8'hA5 || ifm.d_valid !== 1'b1) begin
         bad++;
         $display("FAIL after_reset got=%h v=%b want=a5 v=1", ifm.d_out, ifm.d_valid);
      end
      total++;
      if (ifl.d_out !== 8'hA5 || ifl.d_valid !== 1'b1) begin
         bad++;
         $display("FAIL after_reset_lsb got=%h v=%b want=a5 v=1", ifl.d_out, ifl.d_valid);
      end
   endtask
   initial begin
      test_reset();
      test_order();
      test_overrun();
      test_back_to_back();
      test_gap();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
